trigger_ctrl: RTL and testbench



---
 rtl/trigger_ctrl.sv | 109 ++++++++++
 tb/tb_trigger_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_ctrl.sv
// Trigger controller: qualifies per-channel triggers under an enable mask (AND/OR),
// fires on a rising edge while armed, then counts post-trigger samples to completion.
module trigger_ctrl #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_trig,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              trig_mode,
    input  logic              armed,
    input  logic              smpl,
    input  logic [CNT_W-1:0]  trig_pos,
    input  logic              set_capture_done,
    output logic              triggered,
    output logic              post_done,
    output logic [CNT_W-1:0]  post_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        TRIG,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic               cond, cond_q, cond_d, cond_edge;
    logic [CNT_W-1:0]   post_cnt_q, post_cnt_d;
    logic [CNT_W-1:0]   pos_q, pos_d;
    logic               triggered_q, triggered_d;
    logic               post_done_q, post_done_d;

    // An empty enable mask must never qualify, even in AND mode.
    always_comb begin
        if (trig_mode) begin
            cond = |(ch_trig & ch_en);
        end else begin
            cond = (&(ch_trig | ~ch_en)) & (|ch_en);
        end
    end

    assign cond_d    = cond;
    assign cond_edge = cond & ~cond_q;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        post_cnt_d = post_cnt_q;
        pos_d      = pos_q;

        if (set_capture_done) begin
            state_d    = IDLE;
            post_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (armed) state_d = ARMED;
                end
                ARMED: begin
                    if (!armed) begin
                        state_d = IDLE;
                    end else if (cond_edge) begin
                        state_d    = TRIG;
                        post_cnt_d = '0;
                        pos_d      = trig_pos;
                    end
                end
                TRIG: begin
                    if (smpl && (post_cnt_q != CNT_MAX)) post_cnt_d = post_cnt_q + CNT_W'(1);
                    if (post_cnt_q >= pos_q) state_d = DONE;
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end

        triggered_d = (state_d == TRIG) || (state_d == DONE);
        post_done_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            cond_q      <= 1'b0;
            post_cnt_q  <= '0;
            pos_q       <= '0;
            triggered_q <= 1'b0;
            post_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cond_q      <= cond_d;
            post_cnt_q  <= post_cnt_d;
            pos_q       <= pos_d;
            triggered_q <= triggered_d;
            post_done_q <= post_done_d;
        end
    end

    assign triggered = triggered_q;
    assign post_done = post_done_q;
    assign post_cnt  = post_cnt_q;

endmodule

// File: tb/tb_trigger_ctrl.sv
// Scoreboard bench for trigger_ctrl: a behavioural model pushes expected outputs per cycle,
// each scenario task pops and compares them, plus directed checks at key cycles.
module tb_trigger_ctrl;

    localparam int NUM_CH = 6;
    localparam int CNT_W  = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_trig;
    logic [NUM_CH-1:0] ch_en;
    logic              trig_mode;
    logic              armed;
    logic              smpl;
    logic [CNT_W-1:0]  trig_pos;
    logic              set_capture_done;
    logic              triggered;
    logic              post_done;
    logic [CNT_W-1:0]  post_cnt;

    trigger_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .ch_trig          (ch_trig),
        .ch_en            (ch_en),
        .trig_mode        (trig_mode),
        .armed            (armed),
        .smpl             (smpl),
        .trig_pos         (trig_pos),
        .set_capture_done (set_capture_done),
        .triggered        (triggered),
        .post_done        (post_done),
        .post_cnt         (post_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             trig;
        logic             done;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    localparam int S_IDLE = 0, S_ARMED = 1, S_TRIG = 2, S_DONE = 3;
    int m_st  = S_IDLE;
    bit m_cq  = 1'b0;
    int m_cnt = 0;
    int m_pos = 0;

    function automatic bit model_cond();
        if (ch_en == '0) return 1'b0;
        if (trig_mode) return (ch_trig & ch_en) != '0;
        return (ch_trig & ch_en) == ch_en;
    endfunction

    // Advance model one cycle from the current inputs, push expectation, then clock the DUT.
    task automatic step();
        bit   c;
        int   nst, ncnt, npos;
        exp_t x;
        c    = model_cond();
        nst  = m_st;
        ncnt = m_cnt;
        npos = m_pos;
        if (rst) begin
            nst = S_IDLE; ncnt = 0; npos = 0;
        end else if (set_capture_done) begin
            nst = S_IDLE; ncnt = 0;
        end else if (m_st == S_IDLE) begin
            if (armed) nst = S_ARMED;
        end else if (m_st == S_ARMED) begin
            if (!armed) nst = S_IDLE;
            else if (c && !m_cq) begin
                nst = S_TRIG; ncnt = 0; npos = int'(trig_pos);
            end
        end else if (m_st == S_TRIG) begin
            if (smpl && m_cnt < (1 << CNT_W) - 1) ncnt = m_cnt + 1;
            if (m_cnt >= m_pos) nst = S_DONE;
        end
        x.trig = (nst == S_TRIG) || (nst == S_DONE);
        x.done = (nst == S_DONE) && (m_st != S_DONE);
        x.cnt  = CNT_W'(ncnt);
        exp_q.push_back(x);
        m_cq  = rst ? 1'b0 : c;
        m_st  = nst;
        m_cnt = ncnt;
        m_pos = npos;
        @(posedge clk);
        #1;
    endtask

    task automatic defaults();
        rst = 1'b0; ch_trig = '0; ch_en = '1; trig_mode = 1'b0; armed = 1'b1;
        smpl = 1'b0; trig_pos = 9'd100; set_capture_done = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            defaults();
            rst = 1'b1;
            ch_trig = '1;
            step();
            e = exp_q.pop_front();
            n_checks++;
            if ({triggered, post_done, post_cnt} !== {e.trig, e.done, e.cnt}) begin
                n_errors++;
                $display("FAIL reset c%0d: got trig=%0b done=%0b cnt=%0d, exp trig=%0b done=%0b cnt=%0d",
                         c, triggered, post_done, post_cnt, e.trig, e.done, e.cnt);
            end
        end
        n_checks++;
        if ({triggered, post_done, post_cnt} !== {1'b0, 1'b0, 9'd0}) begin
            n_errors++;
            $display("FAIL reset_values: got trig=%0b done=%0b cnt=%0d, exp 0 0 0", triggered, post_done, post_cnt);
        end
    endtask

    task automatic test_and_mode();
        for (int c = 0; c < 12; c++) begin
            defaults();
            ch_en = 6'b111111;
            if (c == 0) rst = 1'b1;
            if (c >= 2 && c <= 4) ch_trig = 6'b111111;
            if (c == 3) set_capture_done = 1'b1;
            if (c >= 5) ch_trig = (c % 2) ? 6'b111110 : 6'b011110;
            step();
            e = exp_q.pop_front();
            n_checks++;
            if ({triggered, post_done, post_cnt} !== {e.trig, e.done, e.cnt}) begin
                n_errors++;
                $display("FAIL and_mode c%0d: got trig=%0b done=%0b cnt=%0d, exp trig=%0b done=%0b cnt=%0d",
                         c, triggered, post_done, post_cnt, e.trig, e.done, e.cnt);
            end
            if (c == 2 || c == 11) begin
                n_checks++;
                if (triggered !== (c == 2)) begin
                    n_errors++;
                    $display("FAIL and_fire c%0d: triggered=%0b exp %0b", c, triggered, c == 2);
                end
            end
        end
    endtask

    task automatic test_or_mode();
        for (int c = 0; c < 14; c++) begin
            defaults();
            trig_mode = 1'b1;
            ch_en = 6'b000100;
            if (c == 0) rst = 1'b1;
            if (c == 2) ch_trig = 6'b000100;
            if (c == 3) set_capture_done = 1'b1;
            if (c == 5 || c == 7) ch_trig = 6'b000001;
            if (c >= 8) begin
                ch_en     = '0;
                ch_trig   = (c % 2) ? 6'b111111 : 6'b000000;
                trig_mode = c[1];
            end
            step();
            e = exp_q.pop_front();
            n_checks++;
            if ({triggered, post_done, post_cnt} !== {e.trig, e.done, e.cnt}) begin
                n_errors++;
                $display("FAIL or_mode c%0d: got trig=%0b done=%0b cnt=%0d, exp trig=%0b done=%0b cnt=%0d",
                         c, triggered, post_done, post_cnt, e.trig, e.done, e.cnt);
            end
            if (c == 2 || c == 7 || c == 13) begin
                n_checks++;
                if (triggered !== (c == 2)) begin
                    n_errors++;
                    $display("FAIL or_fire c%0d: triggered=%0b exp %0b", c, triggered, c == 2);
                end
            end
        end
    endtask

    task automatic test_armed_edge();
        for (int c = 0; c < 7; c++) begin
            defaults();
            ch_trig = (c == 4) ? 6'b000000 : 6'b111111;
            armed   = (c != 0);
            if (c == 0) rst = 1'b1;
            step();
            e = exp_q.pop_front();
            n_checks++;
            if ({triggered, post_done, post_cnt} !== {e.trig, e.done, e.cnt}) begin
                n_errors++;
                $display("FAIL armed_edge c%0d: got trig=%0b done=%0b cnt=%0d, exp trig=%0b done=%0b cnt=%0d",
                         c, triggered, post_done, post_cnt, e.trig, e.done, e.cnt);
            end
            if (c == 3 || c == 5) begin
                n_checks++;
                if (triggered !== (c == 5)) begin
                    n_errors++;
                    $display("FAIL armed_edge_fire c%0d: triggered=%0b exp %0b", c, triggered, c == 5);
                end
            end
        end
    endtask

    task automatic test_count();
        int pulses = 0;
        for (int c = 0; c < 18; c++) begin
            defaults();
            ch_trig = (c >= 2) ? 6'b111111 : 6'b000000;
            trig_pos = 9'd5;
            if (c == 0) rst = 1'b1;
            if (c >= 3 && (c % 2) == 1) smpl = 1'b1;
            if (c == 16) set_capture_done = 1'b1;
            step();
            e = exp_q.pop_front();
            n_checks++;
            if ({triggered, post_done, post_cnt} !== {e.trig, e.done, e.cnt}) begin
                n_errors++;
                $display("FAIL count c%0d: got trig=%0b done=%0b cnt=%0d, exp trig=%0b done=%0b cnt=%0d",
                         c, triggered, post_done, post_cnt, e.trig, e.done, e.cnt);
            end
            if (post_done === 1'b1) pulses++;
            if (c == 12) begin
                n_checks++;
                if ({post_done, post_cnt} !== {1'b1, 9'd5}) begin
                    n_errors++;
                    $display("FAIL count_done: got done=%0b cnt=%0d, exp done=1 cnt=5", post_done, post_cnt);
                end
            end
            if (c == 15 || c == 16) begin
                n_checks++;
                if ({triggered, post_cnt} !== ((c == 15) ? {1'b1, 9'd5} : {1'b0, 9'd0})) begin
                    n_errors++;
                    $display("FAIL count_hold_clear c%0d: got trig=%0b cnt=%0d", c, triggered, post_cnt);
                end
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_errors++;
            $display("FAIL count_pulses: got %0d post_done pulses, exp 1", pulses);
        end
    endtask

    task automatic test_pos_zero();
        for (int c = 0; c < 6; c++) begin
            defaults();
            trig_pos = '0;
            if (c == 0) rst = 1'b1;
            if (c >= 2) ch_trig = 6'b111111;
            if (c == 2) smpl = 1'b1;
            step();
            e = exp_q.pop_front();
            n_checks++;
            if ({triggered, post_done, post_cnt} !== {e.trig, e.done, e.cnt}) begin
                n_errors++;
                $display("FAIL pos_zero c%0d: got trig=%0b done=%0b cnt=%0d, exp trig=%0b done=%0b cnt=%0d",
                         c, triggered, post_done, post_cnt, e.trig, e.done, e.cnt);
            end
            if (c == 2 || c == 3) begin
                n_checks++;
                if ({triggered, post_done, post_cnt} !== {1'b1, c == 3, 9'd0}) begin
                    n_errors++;
                    $display("FAIL pos_zero_timing c%0d: got trig=%0b done=%0b cnt=%0d", c, triggered, post_done, post_cnt);
                end
            end
        end
    endtask

    task automatic test_ignore_inputs();
        for (int c = 0; c < 12; c++) begin
            defaults();
            ch_trig = (c >= 2) ? 6'b111111 : 6'b000000;
            trig_pos = (c == 2) ? 9'd5 : 9'd2;
            if (c == 0) rst = 1'b1;
            if (c >= 3 && c <= 7) smpl = 1'b1;
            if (c >= 4) begin
                armed     = 1'b0;
                ch_trig   = (c % 2) ? 6'b101010 : 6'b010101;
                trig_mode = c[0];
            end
            if (c == 11) set_capture_done = 1'b1;
            step();
            e = exp_q.pop_front();
            n_checks++;
            if ({triggered, post_done, post_cnt} !== {e.trig, e.done, e.cnt}) begin
                n_errors++;
                $display("FAIL ignore c%0d: got trig=%0b done=%0b cnt=%0d, exp trig=%0b done=%0b cnt=%0d",
                         c, triggered, post_done, post_cnt, e.trig, e.done, e.cnt);
            end
            if (c == 5 || c == 8) begin
                n_checks++;
                if ({triggered, post_done} !== {1'b1, c == 8}) begin
                    n_errors++;
                    $display("FAIL ignore_done c%0d: got trig=%0b done=%0b", c, triggered, post_done);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 7; c++) begin
            defaults();
            if (c == 0) rst = 1'b1;
            if (c >= 2 && c != 4) ch_trig = 6'b111111;
            if (c == 2) set_capture_done = 1'b1;
            step();
            e = exp_q.pop_front();
            n_checks++;
            if ({triggered, post_done, post_cnt} !== {e.trig, e.done, e.cnt}) begin
                n_errors++;
                $display("FAIL back_to_back c%0d: got trig=%0b done=%0b cnt=%0d, exp trig=%0b done=%0b cnt=%0d",
                         c, triggered, post_done, post_cnt, e.trig, e.done, e.cnt);
            end
            if (c == 2 || c == 5) begin
                n_checks++;
                if (triggered !== (c == 5)) begin
                    n_errors++;
                    $display("FAIL clear_vs_edge c%0d: triggered=%0b exp %0b", c, triggered, c == 5);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        for (int c = 0; c < 9; c++) begin
            defaults();
            trig_pos = 9'd10;
            if (c == 0 || c == 6) rst = 1'b1;
            if (c >= 2) ch_trig = 6'b111111;
            if (c >= 3) smpl = 1'b1;
            step();
            e = exp_q.pop_front();
            n_checks++;
            if ({triggered, post_done, post_cnt} !== {e.trig, e.done, e.cnt}) begin
                n_errors++;
                $display("FAIL rst_mid c%0d: got trig=%0b done=%0b cnt=%0d, exp trig=%0b done=%0b cnt=%0d",
                         c, triggered, post_done, post_cnt, e.trig, e.done, e.cnt);
            end
            if (c == 5 || c == 6 || c == 8) begin
                n_checks++;
                if ({triggered, post_cnt} !== ((c == 5) ? {1'b1, 9'd3} : {1'b0, 9'd0})) begin
                    n_errors++;
                    $display("FAIL rst_mid_state c%0d: got trig=%0b cnt=%0d", c, triggered, post_cnt);
                end
            end
        end
    endtask

    initial begin
        defaults();
        rst = 1'b1;
        test_reset();
        test_and_mode();
        test_or_mode();
        test_armed_edge();
        test_count();
        test_pos_zero();
        test_ignore_inputs();
        test_back_to_back();
        test_rst_mid();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
